cpu_run_ctrl: RTL and testbench

//  Run/step sequencer for the multicycle MIPS core on the board. Turns three raw pushbuttons
//  (step, run, stop) plus a PC breakpoint into a single CPU clock-enable, so the core can be

---
 rtl/cpu_run_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: debounced step/run/stop buttons plus a PC breakpoint
// produce the single clock-enable that advances the multicycle CPU.
module cpu_run_ctrl #(
    parameter int unsigned TIMEOUT    = 500000000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned AW         = 32
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             step_btn,
    input  logic             run_btn,
    input  logic             stop_btn,
    input  logic [15:0]      burst_len,
    input  logic             bp_en,
    input  logic [AW-1:0]    bp_addr,
    input  logic [AW-1:0]    pc,
    output logic             cpu_ce,
    output logic             busy,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned NBTN  = 3;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);
    localparam int unsigned BL_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        RUN    = 2'd2,
        BPHALT = 2'd3
    } state_t;

    // Button index: 0 = step, 1 = run, 2 = stop
    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync1;
    logic [NBTN-1:0]  sync2;
    logic [NBTN-1:0]  deb_lvl;
    logic [NBTN-1:0]  deb_lvl_d;
    logic [DEB_W-1:0] deb_cnt [NBTN];
    logic [NBTN-1:0]  rise;

    logic step_p;
    logic run_p;
    logic stop_p;

    state_t            state;
    state_t            state_d;
    logic [BL_W-1:0]   burst_cnt;
    logic [BL_W-1:0]   burst_cnt_d;
    logic [BL_W-1:0]   burst_load;
    logic [RUN_W-1:0]  run_cnt;
    logic [RUN_W-1:0]  run_cnt_d;
    logic              armed;
    logic              active;
    logic              pc_match;
    logic              hit;
    logic              enter;

    assign btn_raw = {stop_btn, run_btn, step_btn};

    // Synchronize, then debounce: level follows the sample only after DEB_CYCLES agreeing samples
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync1     <= '0;
            sync2     <= '0;
            deb_lvl   <= '0;
            deb_lvl_d <= '0;
            for (int i = 0; i < int'(NBTN); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            deb_lvl_d <= deb_lvl;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        deb_lvl[i] <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // One-cycle press pulses, resolved stop > run > step
    always_comb begin
        rise   = deb_lvl & ~deb_lvl_d;
        stop_p = rise[2];
        run_p  = rise[1] & ~rise[2];
        step_p = rise[0] & ~rise[1] & ~rise[2];
    end

    assign burst_load = (burst_len == '0) ? BL_W'(1) : burst_len;

    // Next-state, counters and the combinational clock-enable
    always_comb begin
        state_d     = state;
        burst_cnt_d = burst_cnt;
        run_cnt_d   = run_cnt;
        active      = (state == BURST) || (state == RUN);
        pc_match    = (pc == bp_addr);
        hit         = active & bp_en & armed & pc_match;
        cpu_ce      = active & ~hit;
        enter       = 1'b0;

        case (state)
            IDLE: begin
                if (run_p) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end else if (step_p) begin
                    state_d     = BURST;
                    burst_cnt_d = burst_load;
                end
            end
            BURST: begin
                if (stop_p) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d = BPHALT;
                end else if (run_p) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt - BL_W'(1);
                    if (burst_cnt <= BL_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                if (stop_p) begin
                    state_d = IDLE;
                end else if (hit) begin
                    state_d = BPHALT;
                end else if (run_p) begin
                    run_cnt_d = '0;
                end else if (run_cnt == RUN_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt + RUN_W'(1);
                end
            end
            BPHALT: begin
                if (stop_p) begin
                    state_d = IDLE;
                end else if (run_p) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                end else if (step_p) begin
                    state_d     = BURST;
                    burst_cnt_d = burst_load;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        enter = ((state_d == BURST) && (state != BURST)) ||
                ((state_d == RUN) && (state != RUN));
    end

    // State, counters, breakpoint arm flag and registered status outputs
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
            run_cnt   <= '0;
            armed     <= 1'b0;
            busy      <= 1'b0;
            bp_hit    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state     <= state_d;
            burst_cnt <= burst_cnt_d;
            run_cnt   <= run_cnt_d;
            busy      <= (state_d == BURST) || (state_d == RUN);
            bp_hit    <= (state_d == BPHALT);
            if (cpu_ce) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            // Disarm at the breakpoint PC so resuming there does not re-hit at once
            if (!pc_match) begin
                armed <= 1'b1;
            end else if (hit || enter) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: each enable episode is checked against
// a queued expectation of enabled-cycle count, bp_hit and cycle_cnt.
module tb_cpu_run_ctrl;

    localparam int unsigned AW    = 32;
    localparam int unsigned CNT_W = 32;

    typedef struct {
        int unsigned ce;
        logic        hit;
        logic [31:0] cyc;
    } exp_t;

    logic             clock = 1'b0;
    logic             rst;
    logic             step_btn;
    logic             run_btn;
    logic             stop_btn;
    logic [15:0]      burst_len;
    logic             bp_en;
    logic [AW-1:0]    bp_addr;
    logic [AW-1:0]    pc;
    logic             pc_load;
    logic             cpu_ce;
    logic             busy;
    logic             bp_hit;
    logic [CNT_W-1:0] cycle_cnt;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_total = 0;

    cpu_run_ctrl #(
        .TIMEOUT    (100),
        .DEB_CYCLES (4),
        .CNT_W      (CNT_W),
        .AW         (AW)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .step_btn  (step_btn),
        .run_btn   (run_btn),
        .stop_btn  (stop_btn),
        .burst_len (burst_len),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .pc        (pc),
        .cpu_ce    (cpu_ce),
        .busy      (busy),
        .bp_hit    (bp_hit),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clock = ~clock;

    // Simple core PC model: advances one word per enabled cycle
    always @(posedge clock or negedge rst) begin
        if (!rst)         pc <= 32'h0040_0000;
        else if (pc_load) pc <= 32'h0040_0000;
        else if (cpu_ce)  pc <= pc + 32'd4;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic expect_episode(input int unsigned ce, input logic hit);
        exp_t e;
        exp_total = exp_total + ce;
        e.ce  = ce;
        e.hit = hit;
        e.cyc = 32'(exp_total);
        sb.push_back(e);
    endtask

    // Drive buttons from the current negedge for 'hold' cycles, then allow release to settle
    task automatic press(input logic s, input logic r, input logic t, input int hold);
        step_btn = s;
        run_btn  = r;
        stop_btn = t;
        repeat (hold) @(negedge clock);
        step_btn = 1'b0;
        run_btn  = 1'b0;
        stop_btn = 1'b0;
        repeat (12) @(negedge clock);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (sb.size() == 0) break;
            @(negedge clock);
        end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s_timeout: %0d episodes pending, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: an episode ends when busy falls; compare it with the oldest expectation
    initial begin : monitor
        int unsigned ce_n;
        logic        prev_busy;
        exp_t        e;
        ce_n      = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (!rst) begin
                ce_n      = 0;
                prev_busy = 1'b0;
            end else begin
                if (cpu_ce) ce_n++;
                if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_episode: %0d ce cycles, required none", ce_n);
                    end else begin
                        e = sb.pop_front();
                        check("episode_ce_cycles", 64'(ce_n), 64'(e.ce));
                        check("episode_bp_hit", 64'(bp_hit), 64'(e.hit));
                        check("episode_cycle_cnt", 64'(cycle_cnt), 64'(e.cyc));
                    end
                    ce_n = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : stimulus
        logic [9:0] pat;
        rst       = 1'b1;
        step_btn  = 1'b0;
        run_btn   = 1'b0;
        stop_btn  = 1'b0;
        burst_len = 16'd3;
        bp_en     = 1'b0;
        bp_addr   = '0;
        pc_load   = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("reset_cpu_ce", 64'(cpu_ce), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_bp_hit", 64'(bp_hit), 64'd0);
        check("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        repeat (3) @(negedge clock);
        rst = 1'b1;
        repeat (2) @(negedge clock);

        // Bouncy step press held 10 cycles, burst of 3
        pat = 10'b11_1111_0101;
        expect_episode(3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step_btn = pat[i];
            @(negedge clock);
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clock);
        wait_drain("burst3", 100);
        check("idle_busy_after_burst3", 64'(busy), 64'd0);
        check("idle_ce_after_burst3", 64'(cpu_ce), 64'd0);

        // burst_len 0 behaves as 1
        burst_len = 16'd0;
        expect_episode(1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 8);
        wait_drain("burst0", 100);

        // Free run until timeout
        expect_episode(100, 1'b0);
        press(1'b0, 1'b1, 1'b0, 8);
        wait_drain("run_timeout", 300);
        check("idle_busy_after_timeout", 64'(busy), 64'd0);

        // Second step during a burst does not extend it
        burst_len = 16'd40;
        expect_episode(40, 1'b0);
        press(1'b1, 1'b0, 1'b0, 8);
        press(1'b1, 1'b0, 1'b0, 8);
        wait_drain("burst40", 200);

        // Breakpoint hit in RUN after pc 0x00400000, 04, 08
        bp_en   = 1'b1;
        bp_addr = 32'h0040_000C;
        pc_load = 1'b1;
        @(negedge clock);
        pc_load = 1'b0;
        expect_episode(3, 1'b1);
        press(1'b0, 1'b1, 1'b0, 8);
        wait_drain("bp_run", 100);
        repeat (3) @(negedge clock);
        check("bphalt_bp_hit", 64'(bp_hit), 64'd1);
        check("bphalt_cpu_ce", 64'(cpu_ce), 64'd0);
        check("bphalt_cycle_cnt", 64'(cycle_cnt), 64'(exp_total));

        // Resume with a single step at the breakpoint PC: no re-hit
        burst_len = 16'd1;
        expect_episode(1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 8);
        wait_drain("bp_step", 100);
        repeat (3) @(negedge clock);
        check("after_step_bp_hit", 64'(bp_hit), 64'd0);
        check("after_step_pc", 64'(pc), 64'h0040_0010);

        // Stop and run pulses in the same cycle during RUN: stop wins after 30 enabled cycles
        bp_en = 1'b0;
        expect_episode(30, 1'b0);
        press(1'b0, 1'b1, 1'b0, 8);
        repeat (10) @(negedge clock);
        press(1'b0, 1'b1, 1'b1, 8);
        wait_drain("stop_run", 100);
        repeat (20) @(negedge clock);
        check("stop_run_stays_idle", 64'(busy), 64'd0);
        check("stop_run_cycle_cnt", 64'(cycle_cnt), 64'(exp_total));

        // Asynchronous reset in the middle of RUN
        press(1'b0, 1'b1, 1'b0, 8);
        check("pre_reset_busy", 64'(busy), 64'd1);
        @(posedge clock);
        #3 rst = 1'b0;
        #1;
        check("midrun_reset_cpu_ce", 64'(cpu_ce), 64'd0);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_bp_hit", 64'(bp_hit), 64'd0);
        check("midrun_reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        exp_total = 0;
        @(negedge clock);
        rst = 1'b1;
        repeat (5) @(negedge clock);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
